ppm_shift_two: RTL

Downstream stage of the PPM transmitter frame buffer. It takes one byte at a time over the strobe/done handshake, splits it into four 2-bit symbols (MSB pair first), and emits each symbol as 4-PPM on a single serial line. It returns a one-cycle data_send_done pulse per byte so the buffer advances to the next byte.

---
 rtl/ppm_pkg.sv | 21 ++
 rtl/ppm_slot_timer.sv | 65 ++++++
 rtl/ppm_shift_two.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ppm_pkg.sv
// Shared definitions for the PPM transmitter: FSM encoding and symbol geometry.
package ppm_pkg;

  // One-hot state encoding, same style as the frame buffer upstream.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SEND = 4'b0010,
    ST_DONE = 4'b0100,
    ST_HOLD = 4'b1000
  } state_t;

  localparam int BITS_PER_SYMBOL  = 2;
  localparam int SLOTS_PER_SYMBOL = 4;
  localparam int SYMBOLS_PER_BYTE = 4;

  // Number of SEND cycles needed for one byte.
  function automatic int byte_send_cycles(input int slot_cycles, input int guard_slots);
    return SYMBOLS_PER_BYTE * (SLOTS_PER_SYMBOL + guard_slots) * slot_cycles;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Slot timing for one byte: cycle-within-slot, slot-within-symbol and
// symbol-within-byte counters, plus the window/boundary flags derived from them.
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int SLOT_CYCLES  = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GUARD_SLOTS  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  output logic [2:0] slot,
  output logic [1:0] sym,
  output logic       in_pulse_window,
  output logic       last_cycle_of_symbol,
  output logic       last_cycle_of_byte
);

  localparam int CW = $clog2(SLOT_CYCLES) + 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LEN = CW'(PULSE_CYCLES);
  localparam logic [2:0]    SLOT_LAST = 3'(SLOTS_PER_SYMBOL - 1 + GUARD_SLOTS);
  localparam logic [1:0]    SYM_LAST  = 2'(SYMBOLS_PER_BYTE - 1);

  logic [CW-1:0] cycle_cnt;
  logic [2:0]    slot_cnt;
  logic [1:0]    sym_cnt;
  logic          cyc_end;
  logic          slot_end;

  // Boundary flags and the pulse window, decoded from the current counts.
  always_comb begin
    cyc_end              = (cycle_cnt == CYC_LAST);
    slot_end             = cyc_end && (slot_cnt == SLOT_LAST);
    in_pulse_window      = (cycle_cnt < PULSE_LEN);
    last_cycle_of_symbol = slot_end;
    last_cycle_of_byte   = slot_end && (sym_cnt == SYM_LAST);
    slot                 = slot_cnt;
    sym                  = sym_cnt;
  end

  // Nested counters: cycle wraps into slot, slot wraps into symbol.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_cnt <= '0;
      slot_cnt  <= '0;
      sym_cnt   <= '0;
    end else if (run) begin
      if (cyc_end) begin
        cycle_cnt <= '0;
        if (slot_cnt == SLOT_LAST) begin
          slot_cnt <= '0;
          sym_cnt  <= sym_cnt + 2'd1;
        end else begin
          slot_cnt <= slot_cnt + 3'd1;
        end
      end else begin
        cycle_cnt <= cycle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ppm_shift_two.sv
// Byte-to-4PPM serializer: accepts a byte on strobe, sends four 2-bit symbols
// MSB pair first, pulses done once per byte, then holds off before resampling.
//
// Handshake: shift_two_strobe is a level "byte pending" flag, sampled only in
// IDLE. The byte is taken on the edge where IDLE sees strobe=1. The block
// answers with a single-cycle shift_two_data_send_done after the last slot;
// strobe/data are ignored until HOLD has run HOLDOFF cycles, giving the
// upstream time to present its next byte or drop strobe.
module ppm_shift_two
  import ppm_pkg::*;
#(
  parameter int SLOT_CYCLES  = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GUARD_SLOTS  = 0,
  parameter int HOLDOFF      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_two_strobe,
  input  logic [7:0] data_in,
  output logic       shift_two_data_send_done,
  output logic       ppm_out,
  output logic       busy
);

  localparam int HW = $clog2(HOLDOFF) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    sreg;
  logic [HW-1:0] hold_cnt;
  logic          ppm_nxt;
  logic          accept;

  logic [2:0]    slot;
  logic [1:0]    sym;
  logic          in_pulse_window;
  logic          last_cycle_of_symbol;
  logic          last_cycle_of_byte;

  ppm_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .PULSE_CYCLES(PULSE_CYCLES),
    .GUARD_SLOTS (GUARD_SLOTS)
  ) u_timer (
    .clk                 (clk),
    .rst                 (rst),
    .clear               (accept),
    .run                 (state == ST_SEND),
    .slot                (slot),
    .sym                 (sym),
    .in_pulse_window     (in_pulse_window),
    .last_cycle_of_symbol(last_cycle_of_symbol),
    .last_cycle_of_byte  (last_cycle_of_byte)
  );

  // Next state, handshake outputs and the next PPM line value.
  always_comb begin
    state_nxt                = state;
    accept                   = 1'b0;
    shift_two_data_send_done = 1'b0;
    busy                     = 1'b0;
    ppm_nxt                  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (shift_two_strobe) begin
          accept    = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        busy    = 1'b1;
        ppm_nxt = (slot == {1'b0, sreg[7 -: BITS_PER_SYMBOL]}) && in_pulse_window;
        if (last_cycle_of_byte) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy                     = 1'b1;
        shift_two_data_send_done = 1'b1;
        state_nxt                = ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
      end
      default: begin
        // Any corrupted encoding falls back to IDLE with outputs low.
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Byte register: load on accept, shift one symbol out at each symbol
  // boundary (the final symbol needs no shift, the byte is finished then).
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= data_in;
    end else if ((state == ST_SEND) && last_cycle_of_symbol && (sym != 2'd3)) begin
      sreg <= sreg << BITS_PER_SYMBOL;
    end
  end

  // Holdoff counter, only counts while in HOLD.
  always_ff @(posedge clk) begin
    if (rst)                   hold_cnt <= '0;
    else if (state == ST_HOLD) hold_cnt <= hold_cnt + HW'(1);
    else                       hold_cnt <= '0;
  end

  // Registered PPM line, one cycle behind the slot counters.
  always_ff @(posedge clk) begin
    if (rst) ppm_out <= 1'b0;
    else     ppm_out <= ppm_nxt;
  end

endmodule
